// File: rtl/home_load_arbiter.sv
// home_load_arbiter: safety loads pass straight through; comfort loads share power slots
// via round-robin arbitration with min-on/min-off timers and shedding while safety is active.
module home_load_arbiter #(
  parameter int MAX_ACTIVE = 2,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] req_i,
  output logic [4:0] grant_o,
  output logic [4:0] pending_o,
  output logic [1:0] active_cnt_o,
  output logic       shed_pulse_o
);
  typedef enum logic [1:0] {OFF, ON, COOL} state_e;
  state_e           state_q [3];
  state_e           state_d [3];
  logic [CNT_W-1:0] tmr_q [3];
  logic [CNT_W-1:0] tmr_d [3];
  logic [1:0]       ptr_q, ptr_d, cnt_q, cnt_d, limit, idx;
  logic [4:0]       grant_q, grant_d, pending_q;
  logic [2:0]       on, cand, win, shed_v, on_d;
  logic             shed_q, shed, go;
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return v >= 3'd3 ? 2'(v - 3'd3) : v[1:0];
  endfunction
  assign limit  = 2'(MAX_ACTIVE) - {1'b0, grant_q[0] | grant_q[1]};
  assign shed   = cnt_q > limit;
  assign go     = !shed && (cnt_q < limit);
  assign shed_v = shed ? (on[2] ? 3'b100 : on[1] ? 3'b010 : {2'b00, on[0]}) : 3'b000;
  always_comb begin
    on   = '0;
    cand = '0;
    for (int i = 0; i < 3; i++) begin
      on[i]   = state_q[i] == ON;
      cand[i] = state_q[i] == OFF && req_i[i+2];
    end
  end
  // Scan downward so the candidate closest to the pointer wins last.
  always_comb begin
    win   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = wrap3({1'b0, ptr_q} + 3'(k));
      if (go && cand[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        ptr_d    = wrap3({1'b0, idx} + 3'd1);
      end
    end
  end
  always_comb begin
    on_d = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      if (state_q[i] == OFF && win[i]) begin
        state_d[i] = ON;
        tmr_d[i]   = CNT_W'(MIN_ON - 1);
      end else if (state_q[i] == ON && (shed_v[i] || (!req_i[i+2] && tmr_q[i] == '0))) begin
        state_d[i] = COOL;
        tmr_d[i]   = CNT_W'(MIN_OFF - 1);
      end else if (state_q[i] == COOL && tmr_q[i] == '0) begin
        state_d[i] = OFF;
      end else if (state_q[i] != OFF && tmr_q[i] != '0) begin
        tmr_d[i] = tmr_q[i] - 1'b1;
      end
      on_d[i] = state_d[i] == ON;
    end
  end
  assign grant_d = {on_d, req_i[1:0]};
  assign cnt_d   = 2'(on_d[0]) + 2'(on_d[1]) + 2'(on_d[2]);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q   <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      shed_q    <= 1'b0;
      ptr_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= OFF;
        tmr_q[i]   <= '0;
      end
    end else begin
      grant_q   <= grant_d;
      pending_q <= req_i & ~grant_d;
      cnt_q     <= cnt_d;
      shed_q    <= shed;
      ptr_q     <= ptr_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end
  assign grant_o      = grant_q;
  assign pending_o    = pending_q;
  assign active_cnt_o = cnt_q;
  assign shed_pulse_o = shed_q;
endmodule
